serial_add_sub: RTL and testbench

Bit-serial adder/subtractor with valid/ready handshakes on both sides. It accepts two WIDTH-bit operands and an operation select, then processes one bit per clock, LSB first, through a single registered full-adder cell with a carry flip-flop. It returns the WIDTH-bit result and a carry/borrow flag. It is the word-level counterpart of the team's registered difference/borrow cell: subtract results can be re-added to recover the original operand.

---
 rtl/serial_add_sub_if.sv | 28 ++
 rtl/serial_add_sub.sv | 109 ++++++++++
 tb/tb_serial_add_sub.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_sub_if.sv
// Handshake bundle for serial_add_sub.
//   in_valid/in_ready : operand handshake carrying a, b, op
//   out_valid/out_ready: result handshake carrying result, co
// slave  : the adder side (consumes operands, produces result)
// master : the requester side
interface serial_add_sub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             co;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, co
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, co
  );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor, one bit per clock, LSB first.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : serial_add_sub_if.slave
//          in_valid/in_ready + a, b, op (0: a+b, 1: a-b)
//          out_valid/out_ready + result, co (carry for add, borrow for sub)
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_add_sub_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               c_q, c_d;
  logic               co_q, co_d;
  logic               op_q, op_d;

  // Full-adder cell; subtract inverts b and starts with carry=1 (a + ~b + 1)
  logic bb, sum_bit, carry_nxt;
  assign bb        = sb_q[0] ^ op_q;
  assign sum_bit   = sa_q[0] ^ bb ^ c_q;
  assign carry_nxt = (sa_q[0] & bb) | (sa_q[0] & c_q) | (bb & c_q);

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    co_d     = co_q;
    op_d     = op_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          op_d    = bus.op;
          c_d     = bus.op;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d = {sum_bit, result_q[WIDTH-1:1]};
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        c_d      = carry_nxt;
        cnt_d    = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Borrow is the inverse of the final carry when subtracting
          co_d    = op_q ? ~carry_nxt : carry_nxt;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      co_q     <= 1'b0;
      op_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      co_q     <= co_d;
      op_q     <= op_d;
    end
  end

  // in_ready is held low during reset so nothing is accepted while rst is high
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.co        = co_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed testbench for serial_add_sub (WIDTH=8).
module tb_serial_add_sub;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  serial_add_sub_if #(.WIDTH(WIDTH)) bus ();

  serial_add_sub #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; return just after the edge so outputs have settled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation, wait for the accept, then count cycles to out_valid
  task automatic start_op(input logic [7:0] xa, input logic [7:0] xb,
                          input logic xop, output int lat);
    int guard;
    bus.a        = xa;
    bus.b        = xb;
    bus.op       = xop;
    bus.in_valid = 1'b1;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  // Complete the result handshake
  task automatic finish_op();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_ready_low: got %b want 0", bus.in_ready);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.result, bus.co} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b vld=%b res=%h co=%b want rdy=1 vld=0 res=00 co=0",
               bus.in_ready, bus.out_valid, bus.result, bus.co);
    end
  endtask

  task automatic test_add();
    int lat;
    start_op(8'h5A, 8'h3C, 1'b0, lat);
    n_cmp++;
    if (lat != 8) begin
      n_err++;
      $display("FAIL add_latency: got %0d want 8", lat);
    end
    n_cmp++;
    if ({bus.result, bus.co} !== {8'h96, 1'b0}) begin
      n_err++;
      $display("FAIL add_5a_3c: got res=%h co=%b want res=96 co=0", bus.result, bus.co);
    end
    finish_op();
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL add_return_idle: got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_add_overflow();
    int lat;
    start_op(8'hFF, 8'h01, 1'b0, lat);
    n_cmp++;
    if ({bus.result, bus.co} !== {8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL add_ff_01: got res=%h co=%b want res=00 co=1", bus.result, bus.co);
    end
    finish_op();
    start_op(8'h80, 8'h80, 1'b0, lat);
    n_cmp++;
    if ({bus.result, bus.co} !== {8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL add_80_80: got res=%h co=%b want res=00 co=1", bus.result, bus.co);
    end
    finish_op();
  endtask

  task automatic test_sub();
    int lat;
    start_op(8'h10, 8'h01, 1'b1, lat);
    n_cmp++;
    if (lat != 8) begin
      n_err++;
      $display("FAIL sub_latency: got %0d want 8", lat);
    end
    n_cmp++;
    if ({bus.result, bus.co} !== {8'h0F, 1'b0}) begin
      n_err++;
      $display("FAIL sub_10_01: got res=%h co=%b want res=0f co=0", bus.result, bus.co);
    end
    finish_op();
    start_op(8'h00, 8'h01, 1'b1, lat);
    n_cmp++;
    if ({bus.result, bus.co} !== {8'hFF, 1'b1}) begin
      n_err++;
      $display("FAIL sub_00_01: got res=%h co=%b want res=ff co=1", bus.result, bus.co);
    end
    finish_op();
    start_op(8'h37, 8'h37, 1'b1, lat);
    n_cmp++;
    if ({bus.result, bus.co} !== {8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL sub_37_37: got res=%h co=%b want res=00 co=0", bus.result, bus.co);
    end
    finish_op();
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(8'h12, 8'h34, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a        = 8'($urandom);
      bus.b        = 8'($urandom);
      bus.op       = 1'($urandom);
      tick();
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, bus.result, bus.co} !== {1'b1, 1'b0, 8'h46, 1'b0}) begin
        n_err++;
        $display("FAIL backpressure_hold[%0d]: got vld=%b rdy=%b res=%h co=%b want vld=1 rdy=0 res=46 co=0",
                 i, bus.out_valid, bus.in_ready, bus.result, bus.co);
      end
    end
    bus.in_valid = 1'b0;
    finish_op();
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL backpressure_release: got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
    tick();
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure_no_accept: got rdy=%b want 1", bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int  lat;
    int  guard;
    logic seen_valid;
    bus.a        = 8'h55;
    bus.b        = 8'h11;
    bus.op       = 1'b0;
    bus.in_valid = 1'b1;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.result, bus.co} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL midrun_reset_state: got rdy=%b vld=%b res=%h co=%b want rdy=1 vld=0 res=00 co=0",
               bus.in_ready, bus.out_valid, bus.result, bus.co);
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen_valid = 1'b1;
    end
    n_cmp++;
    if (seen_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_no_out_valid: got seen=%b want 0", seen_valid);
    end
    start_op(8'h01, 8'h02, 1'b0, lat);
    n_cmp++;
    if (lat != 8 || {bus.result, bus.co} !== {8'h03, 1'b0}) begin
      n_err++;
      $display("FAIL midrun_followup: got lat=%0d res=%h co=%b want lat=8 res=03 co=0",
               lat, bus.result, bus.co);
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       qop[$];
    int         cyc;
    int         last_acc;
    int         n_acc;
    int         n_res;
    logic       reload;
    logic [8:0] full;
    logic [7:0] exp_res;
    logic       exp_co;
    cyc      = 0;
    last_acc = -1;
    n_acc    = 0;
    n_res    = 0;
    bus.a         = 8'($urandom);
    bus.b         = 8'($urandom);
    bus.op        = 1'($urandom);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (n_res < 6 && cyc < 200) begin
      reload = 1'b0;
      if (bus.out_valid === 1'b1 && qa.size() > 0) begin
        if (qop[0]) begin
          full    = {1'b0, qa[0]} - {1'b0, qb[0]};
          exp_co  = (qa[0] < qb[0]);
        end else begin
          full    = {1'b0, qa[0]} + {1'b0, qb[0]};
          exp_co  = full[8];
        end
        exp_res = full[7:0];
        n_cmp++;
        if ({bus.result, bus.co} !== {exp_res, exp_co}) begin
          n_err++;
          $display("FAIL stream_result[%0d]: a=%h b=%h op=%b got res=%h co=%b want res=%h co=%b",
                   n_res, qa[0], qb[0], qop[0], bus.result, bus.co, exp_res, exp_co);
        end
        void'(qa.pop_front());
        void'(qb.pop_front());
        void'(qop.pop_front());
        n_res++;
      end
      if (bus.in_ready === 1'b1 && bus.in_valid === 1'b1) begin
        qa.push_back(bus.a);
        qb.push_back(bus.b);
        qop.push_back(bus.op);
        if (last_acc >= 0) begin
          n_cmp++;
          if (cyc - last_acc != 10) begin
            n_err++;
            $display("FAIL stream_interval[%0d]: got %0d want 10", n_acc, cyc - last_acc);
          end
        end
        last_acc = cyc;
        n_acc++;
        reload = 1'b1;
      end
      tick();
      cyc++;
      if (reload) begin
        bus.a  = 8'($urandom);
        bus.b  = 8'($urandom);
        bus.op = 1'($urandom);
        if (n_acc >= 6) bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_cmp++;
    if (n_res != 6) begin
      n_err++;
      $display("FAIL stream_count: got %0d results want 6", n_res);
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_add_overflow();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
